// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of a fixed-latency single-port memory.
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              init_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [3:0] LAT      = 4'(MEM_LAT);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              owner_dma_q, owner_dma_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              dma_gnt_q, dma_gnt_d;
   logic              pick_dma;

`ifdef MEM_ARB_CPU_PRIO_EN
   assign pick_dma = dma_req & ~cpu_req;
`else
   // last_dma_q=0 means CPU was granted last, so DMA wins the first tie
   logic last_dma_q, last_dma_d;
   assign pick_dma = dma_req & (~cpu_req | ~last_dma_q);
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      owner_dma_d = owner_dma_q;
      cpu_gnt_d   = 1'b0;
      dma_gnt_d   = 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
      last_dma_d  = last_dma_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               owner_dma_d = pick_dma;
               we_d        = pick_dma ? dma_we    : cpu_we;
               addr_d      = pick_dma ? dma_addr  : cpu_addr;
               wdata_d     = pick_dma ? dma_wdata : cpu_wdata;
               cnt_d       = LAT;
               cpu_gnt_d   = ~pick_dma;
               dma_gnt_d   = pick_dma;
`ifndef MEM_ARB_CPU_PRIO_EN
               last_dma_d  = pick_dma;
`endif
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!init_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         owner_dma_q <= 1'b0;
         cpu_gnt_q   <= 1'b0;
         dma_gnt_q   <= 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
         last_dma_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         owner_dma_q <= owner_dma_d;
         cpu_gnt_q   <= cpu_gnt_d;
         dma_gnt_q   <= dma_gnt_d;
`ifndef MEM_ARB_CPU_PRIO_EN
         last_dma_q  <= last_dma_d;
`endif
      end
   end

   // Strobes decode from state so a reset drops them on the very next cycle
   assign mem_read  = (state_q == S_ACCESS) & ~we_q;
   assign mem_write = (state_q == S_ACCESS) &  we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign cpu_gnt   = cpu_gnt_q;
   assign dma_gnt   = dma_gnt_q;
   assign cpu_done  = (state_q == S_DONE) & ~owner_dma_q;
   assign dma_done  = (state_q == S_DONE) &  owner_dma_q;
   assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiters (MEM_LAT 1, 3, 4) share one stimulus stream;
// a transaction-level model predicts grants, strobes, done pulses and read data.
module tb_mem_arbiter;

   localparam int N = 3;
   localparam logic [31:0] KEY = 32'hDEADBEFF;  // memory returns addr ^ KEY, so 0x10 -> 0xDEADBEEF

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 4;
   endfunction

   logic        clk = 1'b0;
   logic        init_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
   int          cyc = 0;

   logic        cpu_gnt_w [N], cpu_done_w [N], cpu_stall_w [N];
   logic        dma_gnt_w [N], dma_done_w [N];
   logic        mem_read_w [N], mem_write_w [N];
   logic [31:0] rdata_w [N], mem_addr_w [N], mem_wdata_w [N], mem_rdata_w [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      assign mem_rdata_w[gi] = mem_addr_w[gi] ^ KEY;
      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(gi))) u_dut (
         .clk(clk), .init_n(init_n),
         .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
         .cpu_gnt(cpu_gnt_w[gi]), .cpu_done(cpu_done_w[gi]), .cpu_stall(cpu_stall_w[gi]),
         .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
         .dma_gnt(dma_gnt_w[gi]), .dma_done(dma_done_w[gi]),
         .rdata(rdata_w[gi]),
         .mem_read(mem_read_w[gi]), .mem_write(mem_write_w[gi]),
         .mem_addr(mem_addr_w[gi]), .mem_wdata(mem_wdata_w[gi]), .mem_rdata(mem_rdata_w[gi])
      );
   end

   typedef struct {
      bit          dma;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          t;
   } txn_t;

   txn_t expq [N][$];
   int   rstq [N][$];
   int   free_at [N];
   bit   last_dma [N];
   logic [31:0] last_rd [N];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d cyc=%0d actual=%h expected=%h", nm, i, cyc, act, exp);
      end
   endtask

   // Reference model: applied once per rising edge e with the inputs the DUT samples there.
   task automatic model_edge(input int e);
      for (int i = 0; i < N; i++) begin
         if (!init_n) begin
            free_at[i]  = e + 1;
            last_dma[i] = 1'b0;
            last_rd[i]  = '0;
            rstq[i].push_back(e);
         end else if (e >= free_at[i] && (cpu_req || dma_req)) begin
            txn_t x;
`ifdef MEM_ARB_CPU_PRIO_EN
            x.dma = dma_req && !cpu_req;
`else
            x.dma = dma_req && (!cpu_req || !last_dma[i]);
`endif
            x.we    = x.dma ? dma_we : cpu_we;
            x.addr  = x.dma ? dma_addr : cpu_addr;
            x.wdata = x.dma ? dma_wdata : cpu_wdata;
            x.rd    = x.we ? last_rd[i] : (x.addr ^ KEY);
            x.t     = e;
            last_rd[i]  = x.rd;
            last_dma[i] = x.dma;
            free_at[i]  = e + lat_of(i) + 2;
            expq[i].push_back(x);
         end
      end
   endtask

   task automatic tick();
      model_edge(cyc + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic monitor(input int i);
      txn_t cur;
      bit   active = 1'b0;
      bit   in_acc, dn;
      int   c;
      int   lat = lat_of(i);
      forever begin
         @(negedge clk);
         c = cyc;
         if (c == 0) continue;
         if (rstq[i].size() > 0 && rstq[i][0] == c) begin
            void'(rstq[i].pop_front());
            active = 1'b0;
            chk("rst_gnt", i, {30'd0, cpu_gnt_w[i], dma_gnt_w[i]}, 32'd0);
            chk("rst_done", i, {30'd0, cpu_done_w[i], dma_done_w[i]}, 32'd0);
            chk("rst_strobe", i, {30'd0, mem_read_w[i], mem_write_w[i]}, 32'd0);
            chk("rst_rdata", i, rdata_w[i], 32'd0);
            continue;
         end
         if (cpu_gnt_w[i] || dma_gnt_w[i]) begin
            if (expq[i].size() == 0) begin
               chk("gnt_unexpected", i, {30'd0, cpu_gnt_w[i], dma_gnt_w[i]}, 32'd0);
            end else begin
               cur = expq[i].pop_front();
               chk("gnt_who", i, {30'd0, cpu_gnt_w[i], dma_gnt_w[i]}, cur.dma ? 32'd1 : 32'd2);
               chk("gnt_cycle", i, c, cur.t);
               active = 1'b1;
            end
         end else if (expq[i].size() > 0 && expq[i][0].t <= c) begin
            cur = expq[i].pop_front();
            chk("gnt_missing", i, 32'd0, cur.dma ? 32'd1 : 32'd2);
         end
         in_acc = active && c >= cur.t && c < cur.t + lat;
         chk("mem_read", i, {31'd0, mem_read_w[i]}, {31'd0, in_acc && !cur.we});
         chk("mem_write", i, {31'd0, mem_write_w[i]}, {31'd0, in_acc && cur.we});
         if (in_acc) chk("mem_addr", i, mem_addr_w[i], cur.addr);
         if (in_acc && cur.we) chk("mem_wdata", i, mem_wdata_w[i], cur.wdata);
         dn = active && c == cur.t + lat;
         chk("cpu_done", i, {31'd0, cpu_done_w[i]}, {31'd0, dn && !cur.dma});
         chk("dma_done", i, {31'd0, dma_done_w[i]}, {31'd0, dn && cur.dma});
         chk("cpu_stall", i, {31'd0, cpu_stall_w[i]}, {31'd0, cpu_req && !(dn && !cur.dma)});
         if (dn) begin
            chk("rdata", i, rdata_w[i], cur.rd);
            $display("inst%0d txn %s %s addr=%h wdata=%h gnt@%0d done@%0d rdata=%h", i,
                     cur.dma ? "DMA" : "CPU", cur.we ? "WR" : "RD", cur.addr, cur.wdata,
                     cur.t, c, rdata_w[i]);
            active = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         free_at[i]  = 0;
         last_dma[i] = 1'b0;
         last_rd[i]  = '0;
      end
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none

      // Reset
      init_n = 1'b0;
      repeat (3) tick();
      init_n = 1'b1;
      idle(2);

      // CPU read of 0x10, request dropped right after it is sampled
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      tick();
      idle(8);

      // DMA write 0x20 <- 0x5A5A5A5A, rdata must keep the previous read value
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h5A5A5A5A;
      tick();
      idle(8);

      // Both requesters held high from reset: alternating (or CPU-only) grants
      init_n = 1'b0;
      tick();
      init_n = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
      repeat (30) tick();
      idle(8);

      // Reset in the 2nd ACCESS cycle of a read, then an immediate new request
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
      tick();
      cpu_req = 1'b0;
      tick();
      init_n = 1'b0;
      tick();
      init_n = 1'b1;
      cpu_req = 1'b1; cpu_addr = 32'h40;
      tick();
      idle(8);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         init_n    = ($urandom_range(0, 80) != 0);
         cpu_req   = ($urandom_range(0, 2) != 0);
         dma_req   = ($urandom_range(0, 2) != 0);
         cpu_we    = $urandom_range(0, 1) != 0;
         dma_we    = $urandom_range(0, 1) != 0;
         cpu_addr  = $urandom;
         dma_addr  = $urandom;
         cpu_wdata = $urandom;
         dma_wdata = $urandom;
         tick();
      end
      init_n = 1'b1;
      idle(12);

      for (int i = 0; i < N; i++) chk("pending_txns", i, expq[i].size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read/write latency in cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port init_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports cpu_req, cpu_we  input  1 each  CPU access request and write-enable.
REQ-007 SHALL have ports cpu_addr  input  ADDR_W and cpu_wdata  input  DATA_W  CPU access address and write data.
REQ-008 SHALL have ports cpu_gnt, cpu_done  output  1 each  CPU grant pulse and completion pulse.
REQ-009 SHALL have port cpu_stall  output  1  equal to cpu_req AND NOT cpu_done; the multicycle controller holds its state while this is high.
REQ-010 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt and dma_done, with the same directions and widths as the matching cpu_* ports.
REQ-011 SHALL have port rdata  output  DATA_W  registered read data, shared by both requesters.
REQ-012 SHALL have ports mem_read, mem_write  output  1 each, plus mem_addr  output  ADDR_W and mem_wdata  output  DATA_W.
REQ-013 SHALL have port mem_rdata  input  DATA_W  memory read data.

Function
REQ-014 SHALL implement the state machine IDLE -> ACCESS -> DONE -> IDLE.
REQ-015 In IDLE, if any request is asserted, SHALL latch the winner's we/addr/wdata, pulse that requester's gnt for 1 cycle on the next cycle, and enter ACCESS.
REQ-016 Winner selection SHALL be round-robin: when both requesters are active, the one not granted last wins; after reset, CPU counts as last-granted, so DMA wins the first tie.
REQ-017 In ACCESS, SHALL drive mem_addr/mem_wdata from the latched values and hold mem_read (we=0) or mem_write (we=1) high for exactly MEM_LAT cycles, counted by a 4-bit down-counter.
REQ-018 On the last ACCESS cycle of a read, SHALL register mem_rdata into rdata.
REQ-019 For a write, SHALL leave rdata unchanged.
REQ-020 In DONE, SHALL pulse the owner's done for 1 cycle, then return to IDLE.
REQ-021 Timing: request first sampled at edge T; gnt is high in the cycle after T, mem strobe is high for cycles T+1..T+MEM_LAT, done is high in cycle T+MEM_LAT+1, and the next grant comes no earlier than T+MEM_LAT+3.
REQ-022 SHALL never assert mem_read and mem_write together, and SHALL never grant both requesters in the same cycle.
REQ-023 If a requester drops req during ACCESS, the access SHALL still complete and done SHALL still pulse.
REQ-024 SHALL ignore changes to request inputs outside IDLE.
REQ-025 A req still high in DONE SHALL be arbitrated normally in the following IDLE cycle; no double grant from one held req.
REQ-026 Outside ACCESS, mem_read and mem_write SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values.

Reset
REQ-027 When init_n=0 at a rising edge, SHALL move to IDLE and clear the counter, rdata and the latched we/addr/wdata to 0.
REQ-028 During that reset, SHALL drive all gnt, done, mem_read and mem_write outputs to 0 and set last-granted to CPU.
REQ-029 Reset during ACCESS or DONE SHALL abort the access: the strobe is low from the next cycle and no done is issued.

Configuration
REQ-030 With macro MEM_ARB_CPU_PRIO_EN defined, selection SHALL be fixed priority with CPU always winning ties, and the last-granted register SHALL be omitted.
REQ-031 With MEM_ARB_CPU_PRIO_EN undefined, selection SHALL be the round-robin scheme of REQ-016.

Verification
REQ-032 Bench SHALL cover: reset, then CPU read addr 0x10 with mem_rdata=0xDEADBEEF and MEM_LAT=1 -> cpu_gnt in cycle 1, mem_read in cycle 1, cpu_done and rdata=0xDEADBEEF in cycle 2.
REQ-033 Bench SHALL cover: cpu_req and dma_req both held high from reset with round-robin -> grants in order DMA, CPU, DMA, CPU, spaced MEM_LAT+2 cycles apart; with MEM_ARB_CPU_PRIO_EN defined -> CPU is granted every time.
REQ-034 Bench SHALL cover: DMA write addr 0x20, data 0x5A5A5A5A, MEM_LAT=3 -> mem_write high for exactly 3 cycles with that addr/data, dma_done 1 cycle later, rdata unchanged.
REQ-035 Bench SHALL cover: init_n=0 asserted in the 2nd ACCESS cycle with MEM_LAT=4 -> mem_read low on the next cycle, no done pulse, state IDLE.
REQ-036 Bench SHALL cover: cpu_req dropped in the first ACCESS cycle -> cpu_done still pulses, and no further grant occurs.
